serial_addsub: RTL and testbench

- Multi-cycle, parametrised add/subtract unit. Successor to the single-bit full adder cell.
- Processes CHUNK bits per clock using an internal CHUNK-bit ripple chain built from full-adder cells, with a carry register between chunks.
- Produces a WIDTH-bit sum or difference plus carry, signed-overflow and zero flags.
- Used as an area-reduced ALU add/sub path in the RV32I datapath, behind a start/busy/done handshake.

---
 rtl/serial_addsub.sv | 168 ++++++++++++++++
 tb/tb_serial_addsub.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit. Each clock it adds CHUNK bits through a small
// ripple chain of full-adder cells and keeps the carry in a register between
// chunks. A WIDTH-bit result and its flags are ready after WIDTH/CHUNK cycles.

// One-bit full adder cell. The ripple chain is built from these.
module serial_addsub_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_addsub: CHUNK must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;

    logic [CHUNK:0]   w_c;
    logic [CHUNK-1:0] w_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;
    logic             w_load;

    // Ripple chain for one chunk. w_c[i] is the carry into bit i of the chunk.
    assign w_c[0] = r_carry;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        serial_addsub_fa u_fa (
            .i_a (r_opa[i]),
            .i_b (r_opb[i]),
            .i_c (w_c[i]),
            .o_s (w_sum[i]),
            .o_c (w_c[i+1])
        );
    end

    // The new chunk enters at the MSB end, so after N shifts the first chunk
    // has reached bit 0.
    generate
        if (CHUNK == WIDTH) begin : g_acc_full
            assign w_acc_next = w_sum;
        end else begin : g_acc_shift
            assign w_acc_next = {w_sum, r_acc[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign w_last = (r_cnt == CW'(N - 1));
    // A start is accepted whenever no operation is running, including in FIN.
    assign w_load = (r_state != S_RUN) && start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks, so every register
        // samples values from before the edge no matter the statement order.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the busy/done status decoded from the state.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_FIN;
            end
            S_FIN: begin
                done         = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand latch, chunk processing, and publishing the result on the
    // last chunk edge, which is also the edge that enters FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this block holds only plain registers and no memory arrays,
        // so all of them are reset, including the datapath.
        if (!rst_n) begin
            r_opa      <= '0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else if (w_load) begin
            // Subtraction is a + ~b + 1, so the +1 goes in as the first carry.
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_opa   <= r_opa >> CHUNK;
            r_opb   <= r_opb >> CHUNK;
            r_carry <= w_c[CHUNK];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                // On the last chunk, w_c[CHUNK-1] is the carry into the MSB.
                r_result   <= w_acc_next;
                r_cout     <= w_c[CHUNK];
                r_overflow <= w_c[CHUNK] ^ w_c[CHUNK-1];
                r_zero     <= (w_acc_next == '0);
            end
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub. The main instance uses WIDTH=32, CHUNK=4. Two more
// instances with CHUNK=1 and CHUNK=32 share its inputs and are checked in the
// randomised sweep. Expected values come from a plain-arithmetic model.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;

    logic        busy4, done4, cout4, ovf4, zero4;
    logic [31:0] res4;
    logic        busy1, done1, cout1, ovf1, zero1;
    logic [31:0] res1;
    logic        busy32, done32, cout32, ovf32, zero32;
    logic [31:0] res32;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } ref_t;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy4), .done(done4), .result(res4), .cout(cout4),
        .overflow(ovf4), .zero(zero4)
    );

    serial_addsub #(.WIDTH(32), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(res1), .cout(cout1),
        .overflow(ovf1), .zero(zero1)
    );

    serial_addsub #(.WIDTH(32), .CHUNK(32)) dut_c32 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy32), .done(done32), .result(res32), .cout(cout32),
        .overflow(ovf32), .zero(zero32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unbounded arithmetic, then truncate and classify.
    function automatic ref_t ref_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        ref_t   r;
        logic [32:0] full;
        longint exact;
        full  = s ? ({1'b0, x} + {1'b0, ~y} + 33'd1) : ({1'b0, x} + {1'b0, y});
        exact = s ? (longint'($signed(x)) - longint'($signed(y)))
                  : (longint'($signed(x)) + longint'($signed(y)));
        r.res = full[31:0];
        r.co  = full[32];
        r.ov  = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
        r.z   = (r.res == 32'd0);
        return r;
    endfunction

    task automatic check_res(input string tag, input logic [31:0] res, input logic co,
                             input logic ov, input logic z, input ref_t e);
        check({tag, " result"},   res,   e.res);
        check({tag, " cout"},     32'(co), 32'(e.co));
        check({tag, " overflow"}, 32'(ov), 32'(e.ov));
        check({tag, " zero"},     32'(z),  32'(e.z));
    endtask

    // One operation on the main instance, from an idle state.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s, input string tag);
        ref_t e;
        int   nb;
        e = ref_op(x, y, s);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy4 === 1'b1 && nb < 64) begin
            nb++;
            // Operands and stray start pulses during RUN must not matter.
            a = $urandom; b = $urandom; sub = 1'($urandom);
            start = (nb == 3);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy cycles"}, 32'(nb), 32'd8);
        check({tag, " done"}, 32'(done4), 32'd1);
        check_res(tag, res4, cout4, ovf4, zero4, e);
        @(negedge clk);
        check({tag, " done after"}, 32'(done4), 32'd0);
        check({tag, " busy after"}, 32'(busy4), 32'd0);
        check({tag, " result held"}, res4, e.res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] qa [5];
        logic [31:0] qb [5];
        logic        qs [5];
        logic [31:0] x, y;
        logic        s;
        logic        saw_done;
        ref_t        e;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;

        // 1. Reset state.
        repeat (2) @(negedge clk);
        check("reset busy",     32'(busy4), 32'd0);
        check("reset done",     32'(done4), 32'd0);
        check("reset result",   res4,       32'd0);
        check("reset zero",     32'(zero4), 32'd1);
        check("reset cout",     32'(cout4), 32'd0);
        check("reset overflow", 32'(ovf4),  32'd0);
        rst_n = 1'b1;
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, "add5+3");

        // 2-4. Directed boundary cases.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "add wrap");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add ovf");
        run_op(32'h0000_0003, 32'h0000_0005, 1'b1, "sub borrow");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, "sub ovf");

        // Result must hold across idle cycles.
        e = ref_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        repeat (5) @(negedge clk);
        check("idle hold result", res4, e.res);
        check("idle hold ovf", 32'(ovf4), 32'(e.ov));

        // 5. Continuous start: accepts on cycles 0, 9, 18, ... after the first.
        for (int c = 0; c <= 45; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("b2b busy c0", 32'(busy4), 32'd0);
                check("b2b done c0", 32'(done4), 32'd0);
            end else begin
                check($sformatf("b2b busy c%0d", c), 32'(busy4), 32'((c % 9) != 0));
                check($sformatf("b2b done c%0d", c), 32'(done4), 32'((c % 9) == 0));
                if ((c % 9) == 0) begin
                    e = ref_op(qa[c/9-1], qb[c/9-1], qs[c/9-1]);
                    check_res($sformatf("b2b op%0d", c/9-1), res4, cout4, ovf4, zero4, e);
                end
            end
            a = $urandom; b = $urandom; sub = 1'($urandom);
            start = (c <= 36);
            if ((c % 9) == 0 && c <= 36) begin
                qa[c/9] = a; qb[c/9] = b; qs[c/9] = sub;
            end
        end
        start = 1'b0;

        // 6. Reset during the 4th busy cycle aborts with no done pulse.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy before", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy",   32'(busy4), 32'd0);
        check("abort done",   32'(done4), 32'd0);
        check("abort result", res4,       32'd0);
        check("abort zero",   32'(zero4), 32'd1);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done4 !== 1'b0) saw_done = 1'b1;
            if (done4 === 1'b0 && rst_n === 1'b0) rst_n = 1'b1;
        end
        check("abort no done", 32'(saw_done), 32'd0);
        run_op(32'd1, 32'd1, 1'b0, "after abort");

        // 7. Randomised sweep over CHUNK=4, CHUNK=1 and CHUNK=32 instances.
        repeat (40) @(negedge clk);
        for (int it = 0; it < 24; it++) begin
            case (it)
                0:       begin x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; s = 1'b0; end
                1:       begin x = 32'h8000_0000; y = 32'h8000_0000; s = 1'b0; end
                2:       begin x = 32'h0000_0000; y = 32'h0000_0000; s = 1'b1; end
                3:       begin x = 32'h7FFF_FFFF; y = 32'hFFFF_FFFF; s = 1'b1; end
                default: begin x = $urandom; y = $urandom; s = 1'($urandom); end
            endcase
            e = ref_op(x, y, s);
            a = x; b = y; sub = s; start = 1'b1;
            for (int j = 1; j <= 35; j++) begin
                @(negedge clk);
                if (j == 1) begin
                    start = 1'b0;
                    a = $urandom; b = $urandom; sub = 1'($urandom);
                end
                check($sformatf("sw%0d c4 done j%0d", it, j),  32'(done4),  32'(j == 9));
                check($sformatf("sw%0d c1 done j%0d", it, j),  32'(done1),  32'(j == 33));
                check($sformatf("sw%0d c32 done j%0d", it, j), 32'(done32), 32'(j == 2));
                if (j == 9)  check_res($sformatf("sw%0d c4", it),  res4,  cout4,  ovf4,  zero4,  e);
                if (j == 33) check_res($sformatf("sw%0d c1", it),  res1,  cout1,  ovf1,  zero1,  e);
                if (j == 2)  check_res($sformatf("sw%0d c32", it), res32, cout32, ovf32, zero32, e);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
